i2c_target: RTL and testbench



---
 rtl/i2c_target_pkg.sv | 23 ++
 rtl/i2c_bus_sync.sv | 47 ++++
 rtl/i2c_target.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared I2C target types: FSM state encoding and ACK/NACK bus levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_target_pkg;

   typedef enum logic [3:0] {
      T_IDLE,
      T_ADDR,
      T_ADDR_ACK,
      T_PTR,
      T_PTR_ACK,
      T_WDATA,
      T_WDATA_ACK,
      T_RDATA,
      T_RDATA_ACK,
      T_IGNORE
   } i2c_target_state_e;

   // SDA level in the ninth (acknowledge) bit slot, same as the controller
   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with edge, START and STOP detection.
// Latency: events are flagged 3 clk after the pin edge (2-FF sync + history + registered flag).
// Backpressure: none; one-cycle event pulses, no handshake.
module i2c_bus_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_sda_s,
   output logic o_start_det,
   output logic o_stop_det
);

   logic [1:0] r_scl_sync;
   logic [1:0] r_sda_sync;
   logic       r_scl_d;
   logic       r_sda_d;

   // Synchronize both lines, keep one cycle of history, register the events
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_sync  <= 2'b11;
         r_sda_sync  <= 2'b11;
         r_scl_d     <= 1'b1;
         r_sda_d     <= 1'b1;
         o_scl_rise  <= 1'b0;
         o_scl_fall  <= 1'b0;
         o_sda_s     <= 1'b1;
         o_start_det <= 1'b0;
         o_stop_det  <= 1'b0;
      end else begin
         r_scl_sync  <= {r_scl_sync[0], i_scl};
         r_sda_sync  <= {r_sda_sync[0], i_sda};
         r_scl_d     <= r_scl_sync[1];
         r_sda_d     <= r_sda_sync[1];
         o_scl_rise  <= r_scl_sync[1] & ~r_scl_d;
         o_scl_fall  <= ~r_scl_sync[1] & r_scl_d;
         // sda_s is registered alongside the flags so it lines up with scl_rise
         o_sda_s     <= r_sda_sync[1];
         o_start_det <= r_scl_sync[1] & r_scl_d & r_sda_d & ~r_sda_sync[1];
         o_stop_det  <= r_scl_sync[1] & r_scl_d & ~r_sda_d & r_sda_sync[1];
      end
   end

endmodule

// File: rtl/i2c_target.sv
// I2C target serving a byte-wide register file with pointer write, data write and burst read.
// Latency: acts 1 clk after a synced bus event (4 clk after the pin edge); LOCAL_RDATA is 1 clk.
// Backpressure: none; no clock stretching, the controller owns SCL timing.
module i2c_target
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h1D,
   parameter int         REG_COUNT   = 64,
   parameter logic [7:0] DEVID_VALUE = 8'hE5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SCL,
   inout  wire               SDA,
   input  logic              LOCAL_WE,
   input  logic [7:0]        LOCAL_ADDR,
   input  logic [7:0]        LOCAL_WDATA,
   output logic [7:0]        LOCAL_RDATA,
   output logic              WR_STROBE,
   output logic [7:0]        WR_ADDR,
   output logic              BUSY,
   output i2c_target_state_e DBG_STATE
);

   localparam int         AW       = $clog2(REG_COUNT);
   localparam logic [8:0] LP_COUNT = 9'(REG_COUNT);
   localparam logic [7:0] LP_LAST  = 8'(REG_COUNT - 1);

   i2c_target_state_e r_state;
   logic [2:0]        r_bitcnt;
   logic [7:0]        r_shift;
   logic [7:0]        r_ptr;
   logic              r_rw;
   logic              r_sda_oe;
   logic              r_busy;
   logic              r_wr_strobe;
   logic [7:0]        r_wr_addr;
   logic [7:0]        r_local_rdata;
   logic [7:0]        r_regs [REG_COUNT];

   logic       w_scl_rise;
   logic       w_scl_fall;
   logic       w_sda_s;
   logic       w_start;
   logic       w_stop;
   logic [7:0] w_byte;
   logic       w_ptr_ok;
   logic       w_local_ok;
   logic [7:0] w_ptr_inc;
   logic [7:0] w_rd_byte;
   logic       w_bus_we;

   i2c_bus_sync u_sync (
      .clk         (clk),
      .rst         (rst),
      .i_scl       (SCL),
      .i_sda       (SDA),
      .o_scl_rise  (w_scl_rise),
      .o_scl_fall  (w_scl_fall),
      .o_sda_s     (w_sda_s),
      .o_start_det (w_start),
      .o_stop_det  (w_stop)
   );

   // Open-drain: the target only ever pulls low or lets go
   assign SDA = r_sda_oe ? 1'b0 : 1'bz;

   assign w_byte     = {r_shift[6:0], w_sda_s};
   assign w_ptr_ok   = {1'b0, r_ptr} < LP_COUNT;
   assign w_local_ok = {1'b0, LOCAL_ADDR} < LP_COUNT;
   assign w_ptr_inc  = (r_ptr == LP_LAST) ? 8'h00 : r_ptr + 8'd1;
   // Out-of-range pointers read as zero
   assign w_rd_byte  = w_ptr_ok ? r_regs[r_ptr[AW-1:0]] : 8'h00;
   // A data byte commits on the scl_fall that ends its ACK slot
   assign w_bus_we   = !w_start && !w_stop && (r_state == T_WDATA_ACK) &&
                       w_scl_fall && r_sda_oe && w_ptr_ok;

   assign LOCAL_RDATA = r_local_rdata;
   assign WR_STROBE   = r_wr_strobe;
   assign WR_ADDR     = r_wr_addr;
   assign BUSY        = r_busy;
   assign DBG_STATE   = r_state;

   // Register file: local port first so a same-cycle bus write to the same address wins
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= (i == 0) ? DEVID_VALUE : 8'h00;
         end
         r_local_rdata <= 8'h00;
      end else begin
         if (LOCAL_WE && w_local_ok) r_regs[LOCAL_ADDR[AW-1:0]] <= LOCAL_WDATA;
         if (w_bus_we)               r_regs[r_ptr[AW-1:0]]      <= r_shift;
         r_local_rdata <= w_local_ok ? r_regs[LOCAL_ADDR[AW-1:0]] : 8'h00;
      end
   end

   // Bus protocol FSM; START/STOP override any state, drive changes only on scl_fall
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= T_IDLE;
         r_bitcnt    <= 3'd7;
         r_shift     <= 8'h00;
         r_ptr       <= 8'h00;
         r_rw        <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= 8'h00;
      end else begin
         r_wr_strobe <= w_bus_we;
         if (w_bus_we) r_wr_addr <= r_ptr;
         if (w_start) begin
            r_state  <= T_ADDR;
            r_bitcnt <= 3'd7;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b1;
         end else if (w_stop) begin
            r_state  <= T_IDLE;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               T_ADDR, T_PTR, T_WDATA: begin
                  if (w_scl_rise) begin
                     r_shift  <= w_byte;
                     r_bitcnt <= r_bitcnt - 3'd1;
                     if (r_bitcnt == 3'd0) begin
                        if (r_state == T_ADDR) begin
                           r_rw    <= w_byte[0];
                           r_state <= (w_byte[7:1] == DEV_ADDR) ? T_ADDR_ACK : T_IGNORE;
                        end else if (r_state == T_PTR) begin
                           r_ptr   <= w_byte;
                           r_state <= T_PTR_ACK;
                        end else begin
                           r_state <= T_WDATA_ACK;
                        end
                     end
                  end
               end
               // ACK states: first scl_fall starts the ACK, second one ends it
               T_ADDR_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_sda_oe) begin
                        r_sda_oe <= 1'b1;
                     end else if (!r_rw) begin
                        r_sda_oe <= 1'b0;
                        r_bitcnt <= 3'd7;
                        r_state  <= T_PTR;
                     end else begin
                        r_shift  <= w_rd_byte;
                        r_sda_oe <= ~w_rd_byte[7];
                        r_bitcnt <= 3'd7;
                        r_state  <= T_RDATA;
                     end
                  end
               end
               T_PTR_ACK, T_WDATA_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_sda_oe) begin
                        r_sda_oe <= 1'b1;
                     end else begin
                        r_sda_oe <= 1'b0;
                        r_bitcnt <= 3'd7;
                        r_state  <= T_WDATA;
                        if (r_state == T_WDATA_ACK) r_ptr <= w_ptr_inc;
                     end
                  end
               end
               T_RDATA: begin
                  if (w_scl_fall) begin
                     if (r_bitcnt == 3'd0) begin
                        r_sda_oe <= 1'b0;
                        r_state  <= T_RDATA_ACK;
                     end else begin
                        r_bitcnt <= r_bitcnt - 3'd1;
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_sda_oe <= ~r_shift[6];
                     end
                  end
               end
               // A fall here only follows an ACKed rise, so it starts the next byte
               T_RDATA_ACK: begin
                  if (w_scl_rise) begin
                     if (w_sda_s == ACK) r_ptr   <= w_ptr_inc;
                     else                r_state <= T_IGNORE;
                  end else if (w_scl_fall) begin
                     r_shift  <= w_rd_byte;
                     r_sda_oe <= ~w_rd_byte[7];
                     r_bitcnt <= 3'd7;
                     r_state  <= T_RDATA;
                  end
               end
               T_IDLE, T_IGNORE: r_sda_oe <= 1'b0;
               default: begin
                  r_state  <= T_IDLE;
                  r_sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller plus scoreboard of expected bus/port responses.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_target;
   import i2c_target_pkg::*;

   localparam int H = 8;   // SCL half period in clk cycles

   logic              clk = 1'b0;
   logic              rst;
   logic              scl;
   logic              tb_low;
   logic              local_we;
   logic [7:0]        local_addr;
   logic [7:0]        local_wdata;
   logic [7:0]        local_rdata;
   logic              wr_strobe;
   logic [7:0]        wr_addr;
   logic              busy;
   i2c_target_state_e dbg_state;
   wire               sda_bus;

   pullup (sda_bus);
   assign sda_bus = tb_low ? 1'b0 : 1'bz;

   i2c_target dut (
      .clk         (clk),
      .rst         (rst),
      .SCL         (scl),
      .SDA         (sda_bus),
      .LOCAL_WE    (local_we),
      .LOCAL_ADDR  (local_addr),
      .LOCAL_WDATA (local_wdata),
      .LOCAL_RDATA (local_rdata),
      .WR_STROBE   (wr_strobe),
      .WR_ADDR     (wr_addr),
      .BUSY        (busy),
      .DBG_STATE   (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } sb_item_t;

   sb_item_t   exp_q[$];
   logic [7:0] obs_q[$];
   logic [7:0] wr_exp_q[$];
   int         vectors    = 0;
   int         miscompares = 0;
   logic       watch_nd   = 1'b0;
   int         nd_viol    = 0;

   task automatic expect_v(input string tag, input logic [7:0] v);
      sb_item_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic observe(input logic [7:0] v);
      obs_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [7:0] v, input logic [7:0] act);
      expect_v(tag, v);
      observe(act);
   endtask

   // Scoreboard: pair each observed response with the oldest expectation
   always @(negedge clk) begin
      sb_item_t   e;
      logic [7:0] got;
      while (obs_q.size() > 0) begin
         got = obs_q.pop_front();
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_obs: got %02h, no expectation queued", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e.val) begin
               miscompares++;
               $display("FAIL %s: got %02h, expected %02h", e.tag, got, e.val);
            end
         end
      end
   end

   // Write-strobe monitor: each pulse must match a queued expected address
   always @(negedge clk) begin
      logic [7:0] ea;
      if (wr_strobe === 1'b1) begin
         vectors++;
         if (wr_exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL wr_strobe: unexpected pulse, WR_ADDR=%02h", wr_addr);
         end else begin
            ea = wr_exp_q.pop_front();
            if (wr_addr !== ea) begin
               miscompares++;
               $display("FAIL wr_addr: got %02h, expected %02h", wr_addr, ea);
            end
         end
      end
   end

   // Target must never pull SDA low while watched
   always @(negedge clk) begin
      if (watch_nd && !tb_low && sda_bus !== 1'b1) nd_viol++;
   end

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      tb_low = ~b;
      clk_wait(H);
      scl = 1'b1;
      clk_wait(H / 2);
      r = sda_bus;
      clk_wait(H / 2);
      scl = 1'b0;
   endtask

   task automatic i2c_start();
      tb_low = 1'b1;
      clk_wait(H);
      scl = 1'b0;
   endtask

   task automatic i2c_rstart();
      tb_low = 1'b0;
      clk_wait(H);
      scl = 1'b1;
      clk_wait(H);
      tb_low = 1'b1;
      clk_wait(H);
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      tb_low = 1'b1;
      clk_wait(H);
      scl = 1'b1;
      clk_wait(H);
      tb_low = 1'b0;
      clk_wait(H);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
      bit_xfer(1'b1, ack);
   endtask

   task automatic read_byte(input logic ack_send, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         d[i] = r;
      end
      bit_xfer(ack_send, r);
   endtask

   // Pointer write, repeated START, n-byte read; observes 3 ACKs then n bytes
   task automatic read_seq(input logic [7:0] ptr, input int n);
      logic       a;
      logic [7:0] d;
      i2c_start();
      write_byte(8'h3A, a); observe({7'd0, a});
      write_byte(ptr, a);   observe({7'd0, a});
      i2c_rstart();
      write_byte(8'h3B, a); observe({7'd0, a});
      for (int k = 0; k < n; k++) begin
         read_byte((k == n - 1) ? NACK : ACK, d);
         observe(d);
      end
      i2c_stop();
   endtask

   // Single-byte write; optionally fires LOCAL_WE in the exact clk the bus write commits
   task automatic write_seq(input logic [7:0] ptr, input logic [7:0] data, input logic collide);
      logic a;
      logic r;
      i2c_start();
      write_byte(8'h3A, a); observe({7'd0, a});
      write_byte(ptr, a);   observe({7'd0, a});
      for (int i = 7; i >= 0; i--) bit_xfer(data[i], r);
      tb_low = 1'b0;
      clk_wait(H);
      scl = 1'b1;
      clk_wait(H / 2);
      a = sda_bus;
      clk_wait(H / 2);
      scl = 1'b0;
      if (collide) begin
         clk_wait(3);
         local_we = 1'b1;
         clk_wait(1);
         local_we = 1'b0;
      end
      observe({7'd0, a});
      i2c_stop();
   endtask

   task automatic local_write(input logic [7:0] a, input logic [7:0] d);
      local_addr  = a;
      local_wdata = d;
      local_we    = 1'b1;
      clk_wait(1);
      local_we    = 1'b0;
   endtask

   task automatic expect_acks(input int n);
      for (int i = 0; i < n; i++) expect_v("ack_slot", 8'h00);
   endtask

   task automatic summary();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
   endtask

   initial begin
      #5000000;
      miscompares++;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      summary();
      $finish;
   end

   initial begin
      logic       a;
      logic [7:0] b;
      rst = 1'b1; scl = 1'b1; tb_low = 1'b0;
      local_we = 1'b0; local_addr = 8'h00; local_wdata = 8'h00;
      clk_wait(3);
      // Reset state
      check("rst_state", 8'(T_IDLE), 8'(dbg_state));
      check("rst_busy",  8'h00, {7'd0, busy});
      check("rst_wrstb", 8'h00, {7'd0, wr_strobe});
      check("rst_wradr", 8'h00, wr_addr);
      check("rst_lrdat", 8'h00, local_rdata);
      check("rst_sda",   8'h01, {7'd0, sda_bus});
      rst = 1'b0;
      clk_wait(4);

      // 1: read DEVID
      expect_acks(3); expect_v("devid", 8'hE5);
      read_seq(8'h00, 1);
      clk_wait(6);
      check("t1_busy",  8'h00, {7'd0, busy});
      check("t1_state", 8'(T_IDLE), 8'(dbg_state));

      // 2: write 0x2D <- 0x08, read it back both ways
      expect_acks(3);
      wr_exp_q.push_back(8'h2D);
      write_seq(8'h2D, 8'h08, 1'b0);
      expect_acks(3); expect_v("rd_2d", 8'h08);
      read_seq(8'h2D, 1);
      local_addr = 8'h2D;
      clk_wait(2);
      check("lrd_2d", 8'h08, local_rdata);

      // 3: burst read across the pointer wrap
      local_write(8'h3F, 8'hAA);
      local_write(8'h00, 8'hE5);
      local_write(8'h01, 8'h5C);
      expect_acks(3);
      expect_v("burst0", 8'hAA); expect_v("burst1", 8'hE5); expect_v("burst2", 8'h5C);
      read_seq(8'h3F, 3);

      // 4: foreign address 0x53 is ignored
      nd_viol = 0;
      watch_nd = 1'b1;
      i2c_start();
      check("t4_busy", 8'h01, {7'd0, busy});
      write_byte(8'hA6, a); check("t4_nack_a", 8'h01, {7'd0, a});
      check("t4_ignore", 8'(T_IGNORE), 8'(dbg_state));
      write_byte(8'h00, a); check("t4_nack_p", 8'h01, {7'd0, a});
      write_byte(8'h77, a); check("t4_nack_d", 8'h01, {7'd0, a});
      i2c_stop();
      watch_nd = 1'b0;
      check("t4_nodrive", 8'h00, 8'(nd_viol));
      check("t4_idle", 8'(T_IDLE), 8'(dbg_state));
      local_addr = 8'h00;
      clk_wait(2);
      check("t4_reg0", 8'hE5, local_rdata);

      // 5: reset while the target drives the address ACK
      i2c_start();
      b = 8'h3A;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], a);
      tb_low = 1'b0;
      clk_wait(6);
      check("t5_ack_drv", 8'h00, {7'd0, sda_bus});
      rst = 1'b1;
      clk_wait(1);
      check("t5_sda_rel", 8'h01, {7'd0, sda_bus});
      check("t5_state",   8'(T_IDLE), 8'(dbg_state));
      rst = 1'b0;
      clk_wait(2);
      scl = 1'b1;
      clk_wait(H);
      scl = 1'b0;
      clk_wait(H);
      check("t5_still_idle", 8'(T_IDLE), 8'(dbg_state));
      i2c_stop();
      expect_acks(3); expect_v("t5_devid", 8'hE5);
      read_seq(8'h00, 1);

      // 6: bus write beats LOCAL_WE on the same clk; out-of-range pointer
      local_addr  = 8'h10;
      local_wdata = 8'h33;
      expect_acks(3);
      wr_exp_q.push_back(8'h10);
      write_seq(8'h10, 8'h55, 1'b1);
      clk_wait(2);
      check("t6_lrd_10", 8'h55, local_rdata);
      expect_acks(3); expect_v("t6_rd_10", 8'h55);
      read_seq(8'h10, 1);
      expect_acks(3);
      write_seq(8'hF0, 8'h99, 1'b0);
      expect_acks(3); expect_v("t6_rd_f0", 8'h00);
      read_seq(8'hF0, 1);

      clk_wait(10);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL leftover_exp: got %0d unchecked, expected 0", exp_q.size());
      end
      if (wr_exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_wr_strobe: got %0d pending, expected 0", wr_exp_q.size());
      end
      summary();
      $finish;
   end

endmodule
